// File: rtl/tof_frame_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tof_frame_buf: per-trigger frame buffer for TOF results with timeout and   |
// | abort. Define TOF_INVALID_DROP_EN to skip storing all-ones results.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tof_frame_buf #(
  parameter int TOF_W   = 19,
  parameter int DEPTH   = 8,
  parameter int TMO_CYC = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tri_en,
  input  logic             in_valid,
  input  logic [TOF_W-1:0] tof_data_in,
  input  logic [2:0]       tof_num_cnt,
  input  logic             rd_en,
  output logic [TOF_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             frame_rdy,
  output logic [3:0]       frame_cnt,
  output logic             frame_tmo,
  output logic             err
);

  localparam int c_IDX_W = $clog2(DEPTH);
  localparam int c_PTR_W = c_IDX_W + 1;
  localparam int c_TMR_W = $clog2(TMO_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_COLLECT = 2'd2,
    S_READY   = 2'd3
  } state_t;

  state_t             r_state;
  logic [2:0]         r_exp_cnt;
  logic [2:0]         r_rcv_cnt;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_TMR_W-1:0] r_timer;
  logic               r_marker_seen;
  logic [TOF_W-1:0]   r_mem [DEPTH];

  logic w_drop;
  logic w_full;
  logic w_done;
  logic w_tmo;
  logic w_wr_en;
  logic w_rd_ok;

`ifdef TOF_INVALID_DROP_EN
  assign w_drop = &tof_data_in;
`else
  assign w_drop = 1'b0;
`endif

  assign w_full  = (r_wr_ptr == c_PTR_W'(DEPTH));
  assign w_done  = (r_rcv_cnt == r_exp_cnt);
  // Timer value reached on the edge that closes the frame is TMO_CYC.
  assign w_tmo   = (r_timer == c_TMR_W'(TMO_CYC - 1));
  assign w_wr_en = (r_state == S_COLLECT) && !tri_en && in_valid && !w_done &&
                   r_marker_seen && !w_drop && !w_full;
  assign w_rd_ok = (r_state == S_READY) && rd_en && (r_rd_ptr < r_wr_ptr);

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[c_IDX_W-1:0]] <= tof_data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_exp_cnt     <= '0;
      r_rcv_cnt     <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_timer       <= '0;
      r_marker_seen <= 1'b0;
      rd_data       <= '0;
      rd_valid      <= 1'b0;
      frame_rdy     <= 1'b0;
      frame_cnt     <= '0;
      frame_tmo     <= 1'b0;
      err           <= 1'b0;
    end else begin
      err      <= 1'b0;
      rd_valid <= 1'b0;
      if (tri_en) begin
        r_state   <= S_ARM;
        err       <= (r_state == S_COLLECT) || (r_state == S_READY);
        frame_rdy <= 1'b0;
        frame_cnt <= '0;
        frame_tmo <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (in_valid) err <= 1'b1;
          end
          S_ARM: begin
            r_exp_cnt     <= tof_num_cnt;
            r_rcv_cnt     <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_timer       <= '0;
            r_marker_seen <= 1'b0;
            if (tof_num_cnt == 3'd0) begin
              r_state   <= S_READY;
              frame_rdy <= 1'b1;
              frame_cnt <= '0;
            end else begin
              r_state <= S_COLLECT;
            end
          end
          S_COLLECT: begin
            if (w_done) begin
              // Results arriving after the frame completed are strays.
              r_state   <= S_READY;
              frame_rdy <= 1'b1;
              frame_cnt <= 4'(r_wr_ptr);
              if (in_valid) err <= 1'b1;
            end else if (in_valid) begin
              r_timer <= '0;
              if (!r_marker_seen) begin
                r_marker_seen <= 1'b1;
              end else begin
                if (r_rcv_cnt != 3'd7) r_rcv_cnt <= r_rcv_cnt + 3'd1;
                if (!w_drop) begin
                  if (w_full) err <= 1'b1;
                  else        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                end
              end
            end else if (w_tmo) begin
              r_state   <= S_READY;
              frame_rdy <= 1'b1;
              frame_tmo <= 1'b1;
              frame_cnt <= 4'(r_wr_ptr);
            end else begin
              r_timer <= r_timer + c_TMR_W'(1);
            end
          end
          S_READY: begin
            if (in_valid) err <= 1'b1;
            if (w_rd_ok) begin
              rd_data  <= r_mem[r_rd_ptr[c_IDX_W-1:0]];
              rd_valid <= 1'b1;
              r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
              if (r_rd_ptr + c_PTR_W'(1) == r_wr_ptr) begin
                r_state   <= S_IDLE;
                frame_rdy <= 1'b0;
                frame_tmo <= 1'b0;
                frame_cnt <= '0;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tof_frame_buf.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_tof_frame_buf: table vectors, directed corner cases and randomized      |
// | frames against a frame-level model. Revision: 1.0                          |
// +----------------------------------------------------------------------------+
module tb_tof_frame_buf;

  localparam int TOF_W   = 19;
  localparam int DEPTH   = 8;
  localparam int TMO_CYC = 40;
`ifdef TOF_INVALID_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             tri_en;
  logic             in_valid;
  logic [TOF_W-1:0] tof_data_in;
  logic [2:0]       tof_num_cnt;
  logic             rd_en;
  logic [TOF_W-1:0] rd_data;
  logic             rd_valid;
  logic             frame_rdy;
  logic [3:0]       frame_cnt;
  logic             frame_tmo;
  logic             err;

  tof_frame_buf #(.TOF_W(TOF_W), .DEPTH(DEPTH), .TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .rst(rst), .tri_en(tri_en), .in_valid(in_valid),
    .tof_data_in(tof_data_in), .tof_num_cnt(tof_num_cnt), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .frame_rdy(frame_rdy),
    .frame_cnt(frame_cnt), .frame_tmo(frame_tmo), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int err_count = 0;
  logic [TOF_W-1:0] q_exp[$];

  always @(negedge clk) if (err === 1'b1) err_count++;

  typedef struct packed {
    logic [2:0]                num;
    logic [3:0]                n;
    logic                      mk;
    logic [8:0][TOF_W-1:0]     d;
    logic [3:0]                cnt;
    logic                      tmo;
    logic                      er;
    logic [7:0][TOF_W-1:0]     e;
  } vec_t;

  vec_t tbl [6];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_frame(input logic [2:0] num);
    tof_num_cnt = num;
    tri_en = 1'b1;
    tick;
    tri_en = 1'b0;
    tick;
    err_count = 0;
  endtask

  task automatic send(input logic [TOF_W-1:0] d, input int gap);
    in_valid = 1'b1;
    tof_data_in = d;
    tick;
    in_valid = 1'b0;
    repeat (gap) tick;
  endtask

  task automatic wait_rdy(input string tag);
    int k = 0;
    while (frame_rdy !== 1'b1 && k < 200) begin
      tick;
      k++;
    end
    chk({tag, " frame_rdy"}, 32'(frame_rdy), 32'd1);
  endtask

  task automatic read_check(input string tag, input int maxgap);
    int sz = q_exp.size();
    for (int i = 0; i < sz; i++) begin
      int gap = $urandom_range(0, maxgap);
      repeat (gap) begin
        rd_en = 1'b0;
        tick;
        chk($sformatf("%s idle rd_valid %0d", tag, i), 32'(rd_valid), 32'd0);
      end
      rd_en = 1'b1;
      tick;
      chk($sformatf("%s rd_valid %0d", tag, i), 32'(rd_valid), 32'd1);
      chk($sformatf("%s rd_data %0d", tag, i), 32'(rd_data), 32'(q_exp[i]));
    end
    if (sz > 0) begin
      chk({tag, " frame_rdy after last"}, 32'(frame_rdy), 32'd0);
      chk({tag, " frame_cnt after last"}, 32'(frame_cnt), 32'd0);
      chk({tag, " frame_tmo after last"}, 32'(frame_tmo), 32'd0);
    end
    rd_en = 1'b1;
    tick;
    rd_en = 1'b0;
    chk({tag, " extra pop rd_valid"}, 32'(rd_valid), 32'd0);
    if (sz > 0) chk({tag, " rd_data hold"}, 32'(rd_data), 32'(q_exp[sz-1]));
    tick;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    tri_en = 1'b0;
    in_valid = 1'b0;
    tof_data_in = '0;
    tof_num_cnt = '0;
    rd_en = 1'b0;

    for (int v = 0; v < 6; v++) tbl[v] = '0;
    // Normal frame.
    tbl[0].num = 3; tbl[0].n = 3; tbl[0].mk = 1'b1; tbl[0].cnt = 3;
    tbl[0].d[0] = 19'h00123; tbl[0].d[1] = 19'h00456; tbl[0].d[2] = 19'h00789;
    tbl[0].e[0] = 19'h00123; tbl[0].e[1] = 19'h00456; tbl[0].e[2] = 19'h00789;
    // Out-of-range result handling.
    tbl[1].num = 2; tbl[1].n = 2; tbl[1].mk = 1'b1;
    tbl[1].d[0] = 19'h7FFFF; tbl[1].d[1] = 19'h00042;
    if (DROP) begin
      tbl[1].cnt = 1; tbl[1].e[0] = 19'h00042;
    end else begin
      tbl[1].cnt = 2; tbl[1].e[0] = 19'h7FFFF; tbl[1].e[1] = 19'h00042;
    end
    // Timeout with one result.
    tbl[2].num = 4; tbl[2].n = 1; tbl[2].mk = 1'b1; tbl[2].cnt = 1; tbl[2].tmo = 1'b1;
    tbl[2].d[0] = 19'h00100; tbl[2].e[0] = 19'h00100;
    // Nine results into a seven-result frame.
    tbl[3].num = 7; tbl[3].n = 9; tbl[3].mk = 1'b1; tbl[3].cnt = 7; tbl[3].er = 1'b1;
    for (int j = 0; j < 9; j++) tbl[3].d[j] = 19'(j + 1);
    for (int j = 0; j < 7; j++) tbl[3].e[j] = 19'(j + 1);
    // Zero expected results: ready straight after ARM.
    tbl[4].num = 0; tbl[4].n = 0; tbl[4].mk = 1'b0; tbl[4].cnt = 0;
    // Single result, reached after aborting the empty frame above.
    tbl[5].num = 1; tbl[5].n = 1; tbl[5].mk = 1'b1; tbl[5].cnt = 1;
    tbl[5].d[0] = 19'h55555; tbl[5].e[0] = 19'h55555;

    repeat (3) tick;
    chk("reset rd_valid", 32'(rd_valid), 32'd0);
    chk("reset frame_rdy", 32'(frame_rdy), 32'd0);
    chk("reset frame_cnt", 32'(frame_cnt), 32'd0);
    chk("reset frame_tmo", 32'(frame_tmo), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset rd_data", 32'(rd_data), 32'd0);
    rst = 1'b0;
    tick;

    for (int v = 0; v < 6; v++) begin
      string tag = $sformatf("vec%0d", v);
      q_exp.delete();
      for (int j = 0; j < int'(tbl[v].cnt); j++) q_exp.push_back(tbl[v].e[j]);
      start_frame(tbl[v].num);
      if (tbl[v].mk) send(19'h00010, 0);
      for (int j = 0; j < int'(tbl[v].n); j++) send(tbl[v].d[j], 0);
      wait_rdy(tag);
      chk({tag, " frame_cnt"}, 32'(frame_cnt), 32'(tbl[v].cnt));
      chk({tag, " frame_tmo"}, 32'(frame_tmo), 32'(tbl[v].tmo));
      read_check(tag, 0);
      chk({tag, " err seen"}, 32'(err_count != 0), 32'(tbl[v].er));
    end

    // Exact timeout latency, counted from the last in_valid edge.
    start_frame(3'd4);
    send(19'h00010, 0);
    in_valid = 1'b1;
    tof_data_in = 19'h00100;
    tick;
    in_valid = 1'b0;
    repeat (TMO_CYC - 1) tick;
    chk("tmo early frame_rdy", 32'(frame_rdy), 32'd0);
    tick;
    chk("tmo frame_rdy", 32'(frame_rdy), 32'd1);
    chk("tmo frame_tmo", 32'(frame_tmo), 32'd1);
    chk("tmo frame_cnt", 32'(frame_cnt), 32'd1);
    q_exp.delete();
    q_exp.push_back(19'h00100);
    read_check("tmo", 0);

    // Abort a ready frame that still holds two unread entries.
    start_frame(3'd3);
    send(19'h00010, 0);
    send(19'h00AAA, 0);
    send(19'h00BBB, 0);
    send(19'h00CCC, 0);
    wait_rdy("abort");
    rd_en = 1'b1;
    tick;
    rd_en = 1'b0;
    chk("abort first pop", 32'(rd_data), 32'h00AAA);
    err_count = 0;
    tof_num_cnt = 3'd1;
    tri_en = 1'b1;
    tick;
    tri_en = 1'b0;
    chk("abort err", 32'(err), 32'd1);
    chk("abort frame_rdy", 32'(frame_rdy), 32'd0);
    tick;
    chk("abort err one cycle", 32'(err), 32'd0);
    send(19'h00010, 0);
    send(19'h3ABCD, 1);
    wait_rdy("after abort");
    chk("after abort frame_cnt", 32'(frame_cnt), 32'd1);
    q_exp.delete();
    q_exp.push_back(19'h3ABCD);
    read_check("after abort", 1);
    chk("abort err pulses", 32'(err_count), 32'd1);

    // Reset in the middle of collection.
    start_frame(3'd4);
    send(19'h00010, 0);
    send(19'h01111, 1);
    send(19'h02222, 1);
    rst = 1'b1;
    #2;
    chk("midrst rd_data", 32'(rd_data), 32'd0);
    chk("midrst rd_valid", 32'(rd_valid), 32'd0);
    chk("midrst frame_rdy", 32'(frame_rdy), 32'd0);
    chk("midrst frame_cnt", 32'(frame_cnt), 32'd0);
    chk("midrst frame_tmo", 32'(frame_tmo), 32'd0);
    chk("midrst err", 32'(err), 32'd0);
    tick;
    rst = 1'b0;
    rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("midrst pop %0d", i), 32'(rd_valid), 32'd0);
    end
    rd_en = 1'b0;
    tick;

    // Randomized frames against a frame-level model.
    for (int f = 0; f < 25; f++) begin
      string tag = $sformatf("rnd%0d", f);
      logic [2:0] num = 3'($urandom_range(1, 7));
      int n = $urandom_range(0, 9);
      q_exp.delete();
      start_frame(num);
      send(19'h00010, $urandom_range(0, 2));
      for (int i = 0; i < n; i++) begin
        logic [TOF_W-1:0] d = ($urandom_range(0, 3) == 0) ? '1 : TOF_W'($urandom);
        if (i < int'(num) && !(DROP && (&d)) && q_exp.size() < DEPTH) q_exp.push_back(d);
        send(d, $urandom_range(0, 2));
      end
      wait_rdy(tag);
      chk({tag, " frame_cnt"}, 32'(frame_cnt), 32'(q_exp.size()));
      chk({tag, " frame_tmo"}, 32'(frame_tmo), 32'(n < int'(num)));
      read_check(tag, 2);
      chk({tag, " err seen"}, 32'(err_count != 0), 32'(n > int'(num)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tof_frame_buf.md
TOF_FRAME_BUF -- requirements
Module: tof_frame_buf

Interface
REQ-001 Parameter TOF_W, default 19, width of one TOF result.
REQ-002 Parameter DEPTH, default 8, number of result entries per frame (power of two).
REQ-003 Parameter TMO_CYC, default 1023, collect-timeout in clk cycles.
REQ-004 Port clk, input, 1, the single clock for all logic.
REQ-005 Port rst, input, 1, asynchronous active-high reset.
REQ-006 Port tri_en, input, 1, frame-start pulse (laser trigger).
REQ-007 Port in_valid, input, 1, one-cycle pulse qualifying tof_data_in (driven by tof_cal out_valid).
REQ-008 Port tof_data_in, input, TOF_W, TOF result; all-ones marks out-of-range.
REQ-009 Port tof_num_cnt, input, 3, expected stop-result count for the frame.
REQ-010 Port rd_en, input, 1, reader pop request.
REQ-011 Port rd_data, output, TOF_W, popped result.
REQ-012 Port rd_valid, output, 1, one-cycle pulse qualifying rd_data.
REQ-013 Port frame_rdy, output, 1, high while a closed frame is readable.
REQ-014 Port frame_cnt, output, 4, number of stored entries in the readable frame.
REQ-015 Port frame_tmo, output, 1, high while the readable frame closed by timeout.
REQ-016 Port err, output, 1, one-cycle error pulse (abort, overflow, or stray input).

Function
REQ-017 FSM states: IDLE, ARM, COLLECT, READY; any state transitions to ARM on tri_en (after REQ-028 checks).
REQ-018 ARM lasts exactly one cycle; it latches exp_cnt <= tof_num_cnt, clears wr_ptr, rd_ptr, rcv_cnt, timer, and the start-marker flag, then enters COLLECT.
REQ-019 In COLLECT, the first in_valid is the start-event marker and is discarded without counting.
REQ-020 Each subsequent in_valid increments rcv_cnt (3 bits, saturating at 7) and writes tof_data_in to entry wr_ptr, then increments wr_ptr, subject to REQ-021 and the Configuration section.
REQ-021 A write with wr_ptr == DEPTH is dropped, wr_ptr holds, err pulses.
REQ-022 COLLECT moves to READY the cycle after rcv_cnt == exp_cnt; exp_cnt == 0 moves directly to READY the cycle after ARM with frame_cnt = 0.
REQ-023 Timer increments each COLLECT cycle and reloads on every in_valid; timer == TMO_CYC moves to READY with frame_tmo = 1.
REQ-024 In READY: frame_rdy = 1; frame_cnt = wr_ptr; each rd_en with rd_ptr < wr_ptr drives rd_data = entry[rd_ptr] and rd_valid = 1 on the next cycle, then increments rd_ptr; back-to-back rd_en sustains one result per cycle.
REQ-025 rd_en with rd_ptr == wr_ptr, or outside READY, is ignored: no rd_valid, no err.
REQ-026 READY returns to IDLE on the cycle the last entry's rd_valid is asserted; frame_rdy, frame_tmo, frame_cnt clear in that same cycle.
REQ-027 rd_data holds its last value when rd_valid = 0.
REQ-028 tri_en in COLLECT or READY aborts the frame: buffer contents discarded, err pulses, FSM enters ARM; tri_en in IDLE enters ARM without err.
REQ-029 in_valid in IDLE or READY is ignored and pulses err; in_valid coincident with tri_en is ignored without err.
REQ-030 In ARM, in_valid is ignored without err.

Reset
REQ-031 rst asserted SHALL force, asynchronously, FSM = IDLE; pointers, counters, and timer = 0; rd_data = 0; rd_valid, frame_rdy, frame_tmo, err = 0; frame_cnt = 0.
REQ-032 Entry storage need not be reset; reset mid-frame discards the frame with no rd_valid afterwards.

Configuration
REQ-033 Macro TOF_INVALID_DROP_EN defined: in_valid with tof_data_in all-ones counts in rcv_cnt but is not written to storage (wr_ptr unchanged).
REQ-034 TOF_INVALID_DROP_EN undefined: all-ones results are stored like any other result.

Verification
REQ-035 Verify normal frame: tri_en, tof_num_cnt=3; in_valid data 0x00010 (marker), 0x00123, 0x00456, 0x00789 -> frame_rdy, frame_cnt=3; three back-to-back rd_en -> rd_data 0x00123, 0x00456, 0x00789 on consecutive cycles; then IDLE.
REQ-036 Verify invalid drop: tof_num_cnt=2; results 0x7FFFF, 0x00042 -> with macro, frame_cnt=1 and rd_data 0x00042; without macro, frame_cnt=2.
REQ-037 Verify timeout: tof_num_cnt=4; marker plus one result 0x00100, then silence -> READY exactly TMO_CYC cycles after the last in_valid, with frame_tmo=1 and frame_cnt=1.
REQ-038 Verify overflow: DEPTH=8, tof_num_cnt=7, 9 results sent -> never more than 8 stored, err pulses on overflow writes, frame_cnt=7 (rcv_cnt reaches 7 first).
REQ-039 Verify abort: tri_en during READY with 2 unread entries -> err pulses once, frame_rdy drops, new frame collects cleanly.
REQ-040 Verify reset mid-collect: rst after 2 results -> all outputs at reset values, subsequent rd_en yields no rd_valid.
